// File: rtl/rvx_if_pkg.sv
// Shared constants and types for the RVX instruction-fetch stage.
// Holds the FSM encoding, the bubble instruction and PC arithmetic helpers.
package rvx_if_pkg;

    localparam int BUS_W = 32;

    localparam logic [BUS_W-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [BUS_W-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [BUS_W-1:0] PC_STEP    = 32'd4;
    localparam logic [BUS_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [BUS_W-1:0] align_pc(input logic [BUS_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
// A bubble only replaces the instruction and valid bit; the pc field is left as is.
module if_id_pipe_reg
    import rvx_if_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic [BUS_W-1:0] inst_i,
    input  logic [BUS_W-1:0] pc_i,
    output logic [BUS_W-1:0] inst_o,
    output logic [BUS_W-1:0] pc_o,
    output logic             valid_o
);

    logic [BUS_W-1:0] inst_q, inst_d;
    logic [BUS_W-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            inst_d  = NOP_INST;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (stall_i) begin
            inst_d  = inst_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else if (load_i) begin
            inst_d  = inst_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch pc, keeps at most one memory request in
// flight, parks responses that arrive during a stall and feeds the IF/ID register.
module if_fetch_unit
    import rvx_if_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             jumpEnIn,
    input  logic [BUS_W-1:0] jumpAddrIn,
    input  logic             stallIFIn,
    input  logic             flushIFIn,
    output logic             imemReqOut,
    output logic [BUS_W-1:0] imemAddrOut,
    input  logic             imemGntIn,
    input  logic             imemRspValidIn,
    input  logic [BUS_W-1:0] imemRspDataIn,
    output logic [BUS_W-1:0] instOut_IFID,
    output logic [BUS_W-1:0] pcOut_IFID,
    output logic             validOut_IFID
);

    fetch_state_e     state_q, state_d;
    logic [BUS_W-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic [BUS_W-1:0] hold_inst_q, hold_inst_d;
    logic             deliver;
    logic [BUS_W-1:0] deliver_inst;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        hold_inst_d  = hold_inst_q;
        deliver      = 1'b0;
        deliver_inst = imemRspDataIn;

        if (jumpEnIn) begin
            // A redirect kills whatever is in flight; the response owed to an
            // already-granted request is marked for discard via drop.
            pc_d = align_pc(jumpAddrIn);
            unique case (state_q)
                S_REQ: begin
                    if (imemGntIn) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imemRspValidIn) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD:  state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imemGntIn) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imemRspValidIn) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (stallIFIn) begin
                            hold_inst_d = imemRspDataIn;
                            state_d     = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stallIFIn) begin
                        deliver      = 1'b1;
                        deliver_inst = hold_inst_q;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        if (deliver) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            hold_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    assign imemReqOut  = !rst && (state_q == S_REQ);
    assign imemAddrOut = pc_q;

    if_id_pipe_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flushIFIn),
        .stall_i (stallIFIn),
        .load_i  (deliver),
        .inst_i  (deliver_inst),
        .pc_i    (pc_q),
        .inst_o  (instOut_IFID),
        .pc_o    (pcOut_IFID),
        .valid_o (validOut_IFID)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a single-slot memory responder plus a
// transaction-level reference model of pc, outstanding request, hold and IF/ID.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jumpEnIn;
    logic [31:0] jumpAddrIn;
    logic        stallIFIn;
    logic        flushIFIn;
    logic        imemReqOut;
    logic [31:0] imemAddrOut;
    logic        imemGntIn;
    logic        imemRspValidIn;
    logic [31:0] imemRspDataIn;
    logic [31:0] instOut_IFID;
    logic [31:0] pcOut_IFID;
    logic        validOut_IFID;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .jumpEnIn       (jumpEnIn),
        .jumpAddrIn     (jumpAddrIn),
        .stallIFIn      (stallIFIn),
        .flushIFIn      (flushIFIn),
        .imemReqOut     (imemReqOut),
        .imemAddrOut    (imemAddrOut),
        .imemGntIn      (imemGntIn),
        .imemRspValidIn (imemRspValidIn),
        .imemRspDataIn  (imemRspDataIn),
        .instOut_IFID   (instOut_IFID),
        .pcOut_IFID     (pcOut_IFID),
        .validOut_IFID  (validOut_IFID)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    // Bench-side memory: one pending response slot.
    bit          mem_pending;
    logic [31:0] mem_addr;

    // Reference model state (transaction view of the fetch stage).
    logic [31:0] m_pc;
    bit          m_busy;        // a granted request still owes a response
    bit          m_drop;        // that response must be thrown away
    bit          m_held;        // a response is parked waiting for stall release
    logic [31:0] m_held_inst;
    logic [31:0] m_if_inst;
    logic [31:0] m_if_pc;
    bit          m_if_valid;
    bit          m_if_pc_known;

    task automatic model_reset();
        m_pc          = 32'h0;
        m_busy        = 1'b0;
        m_drop        = 1'b0;
        m_held        = 1'b0;
        m_held_inst   = NOP;
        m_if_inst     = NOP;
        m_if_pc       = 32'h0;
        m_if_valid    = 1'b0;
        m_if_pc_known = 1'b1;
    endtask

    task automatic model_step();
        bit          dlv;
        logic [31:0] dinst;
        dlv   = 1'b0;
        dinst = 32'h0;
        if (rst) begin
            model_reset();
            return;
        end
        if (jumpEnIn) begin
            m_pc = jumpAddrIn & 32'hFFFF_FFFC;
            if (m_held) begin
                m_held = 1'b0;
            end else if (m_busy) begin
                if (imemRspValidIn) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (imemGntIn) begin
                m_busy = 1'b1;
                m_drop = 1'b1;
            end
        end else if (m_held) begin
            if (!stallIFIn) begin
                dlv    = 1'b1;
                dinst  = m_held_inst;
                m_held = 1'b0;
            end
        end else if (m_busy) begin
            if (imemRspValidIn) begin
                m_busy = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                end else if (stallIFIn) begin
                    m_held      = 1'b1;
                    m_held_inst = imemRspDataIn;
                end else begin
                    dlv   = 1'b1;
                    dinst = imemRspDataIn;
                end
            end
        end else if (imemGntIn) begin
            m_busy = 1'b1;
        end

        if (flushIFIn) begin
            m_if_inst     = NOP;
            m_if_pc       = 32'h0;
            m_if_valid    = 1'b0;
            m_if_pc_known = 1'b1;
        end else if (stallIFIn) begin
            // everything held
        end else if (dlv) begin
            m_if_inst     = dinst;
            m_if_pc       = m_pc;
            m_if_valid    = 1'b1;
            m_if_pc_known = 1'b1;
        end else begin
            m_if_inst     = NOP;
            m_if_valid    = 1'b0;
            m_if_pc_known = 1'b0;
        end
        if (dlv) m_pc = m_pc + 32'd4;
    endtask

    initial begin
        int          gnt_pct, rsp_pct, stall_pct, jump_pct, flush_pct, rst_pct;
        bit          exp_req;
        bit          g, r;
        logic [31:0] jt;

        rst            = 1'b1;
        jumpEnIn       = 1'b0;
        jumpAddrIn     = 32'h0;
        stallIFIn      = 1'b0;
        flushIFIn      = 1'b0;
        imemGntIn      = 1'b0;
        imemRspValidIn = 1'b0;
        imemRspDataIn  = 32'h0;
        mem_pending    = 1'b0;
        mem_addr       = 32'h0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_req = !rst && !m_busy && !m_held;
            check_eq("imem_req", {31'h0, imemReqOut}, {31'h0, exp_req});
            if (exp_req) check_eq("imem_addr", imemAddrOut, m_pc);
            check_eq("ifid_valid", {31'h0, validOut_IFID}, {31'h0, m_if_valid});
            check_eq("ifid_inst", instOut_IFID, m_if_inst);
            if (m_if_pc_known) check_eq("ifid_pc", pcOut_IFID, m_if_pc);

            if (cyc < 400) begin
                gnt_pct = 100; rsp_pct = 100; stall_pct = 0;  jump_pct = 0;  flush_pct = 0; rst_pct = 0;
            end else if (cyc < 1200) begin
                gnt_pct = 60;  rsp_pct = 60;  stall_pct = 35; jump_pct = 0;  flush_pct = 0; rst_pct = 0;
            end else begin
                gnt_pct = 60;  rsp_pct = 55;  stall_pct = 30; jump_pct = 12; flush_pct = 8; rst_pct = 2;
            end

            rst       = ($urandom_range(99) < rst_pct);
            stallIFIn = ($urandom_range(99) < stall_pct);
            flushIFIn = ($urandom_range(99) < flush_pct);
            jumpEnIn  = ($urandom_range(99) < jump_pct);
            jt = $urandom;
            if ($urandom_range(3) == 0) jt = 32'hFFFF_FFFD;
            jumpAddrIn = jt;
            #1;
            g = imemReqOut && !mem_pending && ($urandom_range(99) < gnt_pct);
            r = mem_pending && ($urandom_range(99) < rsp_pct);
            imemGntIn      = g;
            imemRspValidIn = r;
            imemRspDataIn  = r ? mem_word(mem_addr) : $urandom;
            if (r) mem_pending = 1'b0;
            if (g) begin
                mem_pending = 1'b1;
                mem_addr    = imemAddrOut;
            end
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
